// File: rtl/rv_plic_core_param.sv
// PLIC core: per-source gateways feeding a registered max-priority / min-ID arbiter per target.
// Optional macro RV_PLIC_EDGE_CNT_EN keeps a saturating count of edges that arrive while a source is busy.
module rv_plic_core_param #(
  parameter int NumSrc    = 65,
  parameter int NumTarget = 2,
  parameter int MaxPrio   = 7,
  parameter int EdgeCntW  = 4,
  localparam int PrioW = $clog2(MaxPrio + 1),
  localparam int SrcW  = $clog2(NumSrc)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumSrc-1:0]                   src_i,
  input  logic [NumSrc-1:0]                   le_i,
  input  logic [NumSrc-1:0][PrioW-1:0]        prio_i,
  input  logic [NumTarget-1:0][NumSrc-1:0]    ie_i,
  input  logic [NumTarget-1:0][PrioW-1:0]     threshold_i,
  input  logic [NumTarget-1:0]                claim_i,
  input  logic [NumTarget-1:0]                complete_i,
  input  logic [NumTarget-1:0][SrcW-1:0]      complete_id_i,
  output logic [NumSrc-1:0]                   ip_o,
  output logic [NumTarget-1:0]                irq_o,
  output logic [NumTarget-1:0][SrcW-1:0]      irq_id_o
);

  typedef enum logic [1:0] {IDLE, PEND, SERV} gw_state_e;

  if (NumSrc < 2 || NumTarget < 1 || MaxPrio < 1 || EdgeCntW < 1) begin : gen_bad_cfg
    $error("rv_plic_core_param: invalid parameter set");
  end

  logic [NumSrc-1:0] src_q;
  logic [NumSrc-1:0] edge_det;
  logic [NumSrc-1:0] claim_hit;
  logic [NumSrc-1:0] complete_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q <= '0;
    end else begin
      src_q <= src_i;
    end
  end

  assign edge_det = src_i & ~src_q;

  // Claims and completes from all targets collapse into one hit vector; ID 0 can never hit.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int t = 0; t < NumTarget; t++) begin
      for (int s = 1; s < NumSrc; s++) begin
        if (claim_i[t] && irq_id_o[t] == SrcW'(s)) begin
          claim_hit[s] = 1'b1;
        end
        if (complete_i[t] && complete_id_i[t] == SrcW'(s)) begin
          complete_hit[s] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NumSrc; g++) begin : gen_gw
    localparam bit Active = (g != 0);
    gw_state_e state_q, state_d;
    logic      trigger;
    logic      backlog;

    assign trigger = le_i[g] ? edge_det[g] : src_i[g];

`ifdef RV_PLIC_EDGE_CNT_EN
    logic [EdgeCntW-1:0] cnt_q, cnt_d;
    logic                cnt_inc, cnt_dec;

    // An edge landing in the same cycle as the complete is folded straight into the re-pend.
    always_comb begin
      cnt_inc = le_i[g] && edge_det[g] && (state_q != IDLE) && (cnt_q != '1);
      backlog = (cnt_q != '0) || cnt_inc;
      cnt_dec = (state_q == SERV) && complete_hit[g] && backlog;
      cnt_d   = cnt_q + EdgeCntW'(cnt_inc) - EdgeCntW'(cnt_dec);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
`else
    assign backlog = 1'b0;
`endif

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (Active && trigger) state_d = PEND;
        PEND:    if (claim_hit[g]) state_d = SERV;
        SERV:    if (complete_hit[g]) state_d = backlog ? PEND : IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    assign ip_o[g] = Active && (state_q == PEND);
  end

  logic [NumTarget-1:0][SrcW-1:0] win_id;
  logic [PrioW-1:0]               best_prio;

  // Ascending scan with a strict compare keeps the lowest ID among equal priorities.
  always_comb begin
    win_id    = '0;
    best_prio = '0;
    for (int t = 0; t < NumTarget; t++) begin
      best_prio = '0;
      for (int s = 0; s < NumSrc; s++) begin
        if (ip_o[s] && ie_i[t][s] && (prio_i[s] > threshold_i[t]) && (prio_i[s] > best_prio)) begin
          best_prio = prio_i[s];
          win_id[t] = SrcW'(s);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o    <= '0;
      irq_id_o <= '0;
    end else begin
      for (int t = 0; t < NumTarget; t++) begin
        irq_o[t] <= (win_id[t] != '0);
      end
      irq_id_o <= win_id;
    end
  end

endmodule

// File: tb/tb_rv_plic_core_param.sv
// Self-checking bench for rv_plic_core_param: directed scenarios plus a random phase against a
// gateway/arbiter model; honours RV_PLIC_EDGE_CNT_EN.
module tb_rv_plic_core_param;

  localparam int NS  = 65;
  localparam int NT  = 2;
  localparam int MP  = 7;
  localparam int ECW = 4;
  localparam int PW  = $clog2(MP + 1);
  localparam int SW  = $clog2(NS);
  localparam int CntMax = (1 << ECW) - 1;

`ifdef RV_PLIC_EDGE_CNT_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0]          src, le;
  logic [NS-1:0][PW-1:0]  prio;
  logic [NT-1:0][NS-1:0]  ie;
  logic [NT-1:0][PW-1:0]  thr;
  logic [NT-1:0]          claim, complete;
  logic [NT-1:0][SW-1:0]  cid;
  logic [NS-1:0]          ip;
  logic [NT-1:0]          irq;
  logic [NT-1:0][SW-1:0]  irq_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_plic_core_param #(
    .NumSrc(NS), .NumTarget(NT), .MaxPrio(MP), .EdgeCntW(ECW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .prio_i(prio), .ie_i(ie),
    .threshold_i(thr), .claim_i(claim), .complete_i(complete), .complete_id_i(cid),
    .ip_o(ip), .irq_o(irq), .irq_id_o(irq_id)
  );

  // Model: each source is idle, pending or in service, plus a queued-edge count.
  bit  pend[NS];
  bit  serv[NS];
  bit  sprev[NS];
  int  qcnt[NS];
  logic [NT-1:0]         exp_irq;
  logic [NT-1:0][SW-1:0] exp_id;
  logic [NS-1:0]         exp_ip;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NS; s++) begin
      pend[s] = 1'b0; serv[s] = 1'b0; sprev[s] = 1'b0; qcnt[s] = 0;
    end
    exp_irq = '0; exp_id = '0; exp_ip = '0;
  endtask

  task automatic modelStep();
    bit claimed[NS];
    bit done[NS];
    bit found;
    bit rise;
    logic [NT-1:0][SW-1:0] nid;
    for (int s = 0; s < NS; s++) begin
      claimed[s] = 1'b0; done[s] = 1'b0;
    end
    for (int t = 0; t < NT; t++) begin
      if (claim[t] && exp_id[t] != 0) claimed[exp_id[t]] = 1'b1;
      if (complete[t] && cid[t] != 0 && cid[t] < NS) done[cid[t]] = 1'b1;
    end
    // Winner: search priorities from the top, and within one priority the smallest ID.
    nid = '0;
    for (int t = 0; t < NT; t++) begin
      found = 1'b0;
      for (int p = MP; p >= 1 && !found; p--) begin
        if (p > thr[t]) begin
          for (int s = 1; s < NS && !found; s++) begin
            if (pend[s] && ie[t][s] && prio[s] == p) begin
              nid[t] = SW'(s);
              found  = 1'b1;
            end
          end
        end
      end
      exp_irq[t] = found;
    end
    exp_id = nid;
    for (int s = 1; s < NS; s++) begin
      rise = src[s] && !sprev[s];
      if (!pend[s] && !serv[s]) begin
        if (le[s] ? rise : src[s]) pend[s] = 1'b1;
      end else begin
        if (EdgeEn && le[s] && rise && qcnt[s] < CntMax) qcnt[s]++;
        if (pend[s] && claimed[s]) begin
          pend[s] = 1'b0; serv[s] = 1'b1;
        end else if (serv[s] && done[s]) begin
          serv[s] = 1'b0;
          if (qcnt[s] > 0) begin
            qcnt[s]--; pend[s] = 1'b1;
          end
        end
      end
      sprev[s] = src[s];
    end
    for (int s = 0; s < NS; s++) exp_ip[s] = pend[s];
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else modelStep();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("cyc_ip", 128'(ip), 128'(exp_ip));
        for (int t = 0; t < NT; t++) begin
          checkOutput($sformatf("cyc_irq%0d", t), 128'(irq[t]), 128'(exp_irq[t]));
          checkOutput($sformatf("cyc_id%0d", t), 128'(irq_id[t]), 128'(exp_id[t]));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearInputs();
    src = '0; le = '0; prio = '0; ie = '0; thr = '0;
    claim = '0; complete = '0; cid = '0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    clearInputs();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int s, input int p, input bit edge_mode, input logic [NT-1:0] en);
    prio[s] = PW'(p);
    le[s]   = edge_mode;
    for (int t = 0; t < NT; t++) ie[t][s] = en[t];
  endtask

  task automatic pulseClaim(input logic [NT-1:0] mask);
    claim = mask;
    tick();
    claim = '0;
  endtask

  task automatic pulseComplete(input int t, input int id);
    complete[t] = 1'b1;
    cid[t]      = SW'(id);
    tick();
    complete = '0;
    cid      = '0;
  endtask

  initial begin
    clearInputs();
    resetDut();
    checkOutput("rst_ip", 128'(ip), 128'(0));
    checkOutput("rst_irq", 128'(irq), 128'(0));
    checkOutput("rst_id", 128'(irq_id), 128'(0));

    // Level source 5: latency, claim, stale ID, re-pend after complete.
    applyStimulus(5, 3, 1'b0, 2'b01);
    src[5] = 1'b1;
    tick();
    checkOutput("lvl_ip_rise", 128'(ip[5]), 128'(1));
    checkOutput("lvl_irq_wait", 128'(irq[0]), 128'(0));
    tick();
    checkOutput("lvl_irq", 128'(irq[0]), 128'(1));
    checkOutput("lvl_id", 128'(irq_id[0]), 128'(5));
    pulseClaim(2'b01);
    checkOutput("lvl_ip_clr", 128'(ip[5]), 128'(0));
    checkOutput("lvl_stale_id", 128'(irq_id[0]), 128'(5));
    tick();
    checkOutput("lvl_irq_clr", 128'(irq[0]), 128'(0));
    pulseComplete(0, 5);
    tick();
    checkOutput("lvl_repend_ip", 128'(ip[5]), 128'(1));
    tick();
    checkOutput("lvl_repend_id", 128'(irq_id[0]), 128'(5));

    // Tie-break, priority raise, threshold masking.
    resetDut();
    applyStimulus(3, 4, 1'b0, 2'b01);
    applyStimulus(9, 4, 1'b0, 2'b01);
    src[3] = 1'b1; src[9] = 1'b1;
    tick(2);
    checkOutput("tie_id", 128'(irq_id[0]), 128'(3));
    prio[9] = PW'(5);
    tick();
    checkOutput("prio_raise_id", 128'(irq_id[0]), 128'(9));
    thr[0] = PW'(5);
    tick();
    checkOutput("thr_mask_irq", 128'(irq[0]), 128'(0));
    checkOutput("thr_mask_id", 128'(irq_id[0]), 128'(0));
    thr[0] = PW'(MP);
    prio[3] = PW'(MP);
    tick();
    checkOutput("thr_max_irq", 128'(irq[0]), 128'(0));

    // Two targets claiming the same ID together.
    resetDut();
    applyStimulus(7, 2, 1'b0, 2'b11);
    src[7] = 1'b1;
    tick();
    src[7] = 1'b0;
    tick();
    checkOutput("dual_id0", 128'(irq_id[0]), 128'(7));
    checkOutput("dual_id1", 128'(irq_id[1]), 128'(7));
    pulseClaim(2'b11);
    checkOutput("dual_ip_clr", 128'(ip[7]), 128'(0));
    pulseComplete(1, 7);
    pulseComplete(0, 7);
    tick();
    checkOutput("dual_irq_off", 128'(irq), 128'(0));
    src[7] = 1'b1;
    tick();
    src[7] = 1'b0;
    checkOutput("dual_repend_ip", 128'(ip[7]), 128'(1));

    // Edge source 12 with three edges while in service.
    resetDut();
    applyStimulus(12, 1, 1'b1, 2'b01);
    src[12] = 1'b1;
    tick();
    src[12] = 1'b0;
    tick();
    checkOutput("edge_id", 128'(irq_id[0]), 128'(12));
    pulseClaim(2'b01);
    repeat (3) begin
      src[12] = 1'b1;
      tick();
      src[12] = 1'b0;
      tick();
    end
    checkOutput("edge_serv_ip", 128'(ip[12]), 128'(0));
    pulseComplete(0, 12);
    checkOutput("edge_after_cpl_ip", 128'(ip[12]), 128'(EdgeEn));
    for (int k = 0; k < (EdgeEn ? 3 : 0); k++) begin
      tick();
      checkOutput("edge_requeue_id", 128'(irq_id[0]), 128'(12));
      pulseClaim(2'b01);
      pulseComplete(0, 12);
    end
    tick(2);
    checkOutput("edge_final_ip", 128'(ip[12]), 128'(0));
    checkOutput("edge_final_irq", 128'(irq[0]), 128'(0));

    // Ignored completes, then async reset while in service.
    resetDut();
    applyStimulus(20, 2, 1'b0, 2'b10);
    applyStimulus(21, 1, 1'b0, 2'b10);
    src[20] = 1'b1;
    tick(2);
    checkOutput("ign_id_before", 128'(irq_id[1]), 128'(20));
    pulseComplete(0, 20);
    pulseComplete(0, 0);
    pulseComplete(1, 70);
    pulseComplete(0, 33);
    checkOutput("ign_ip", 128'(ip[20]), 128'(1));
    checkOutput("ign_id", 128'(irq_id[1]), 128'(20));
    pulseClaim(2'b10);
    src[21] = 1'b1;
    tick(2);
    checkOutput("serv_ip20", 128'(ip[20]), 128'(0));
    checkOutput("serv_id21", 128'(irq_id[1]), 128'(21));
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ip", 128'(ip), 128'(0));
    checkOutput("async_rst_irq", 128'(irq), 128'(0));
    checkOutput("async_rst_id", 128'(irq_id), 128'(0));

    // Random traffic on sources 1..20 against the model.
    resetDut();
    for (int s = 1; s <= 20; s++) begin
      applyStimulus(s, $urandom_range(0, MP), 1'($urandom_range(0, 1)), NT'($urandom_range(0, 3)));
    end
    for (int c = 0; c < 600; c++) begin
      for (int s = 1; s <= 20; s++) src[s] = ($urandom_range(0, 3) == 0);
      for (int t = 0; t < NT; t++) begin
        claim[t]    = ($urandom_range(0, 2) == 0);
        complete[t] = ($urandom_range(0, 2) == 0);
        cid[t]      = ($urandom_range(0, 9) == 0) ? SW'(100) : SW'($urandom_range(0, 21));
        if (c % 75 == 0) thr[t] = PW'($urandom_range(0, 3));
      end
      if (c % 40 == 0) prio[$urandom_range(1, 20)] = PW'($urandom_range(0, MP));
      tick();
    end
    clearInputs();
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
